// File: rtl/pos_drain_if.sv
// pos_drain_if: capture-side and beat-stream signals between the register file, pos_drain and the descriptor/NMS stage.
interface pos_drain_if #(
    parameter int ADDR_W = 15,
    parameter int N_POS  = 16,
    parameter int CNT_W  = 5
);
    localparam int IDX_W = $clog2(N_POS);
    logic                    start;
    logic [N_POS*ADDR_W-1:0] position;
    logic [N_POS-1:0]        matMask;
    logic                    posReaden;
    logic [ADDR_W-1:0]       outAddr;
    logic [IDX_W-1:0]        outIdx;
    logic                    outValid;
    logic                    outReady;
    logic                    busy;
    logic                    done;
    logic [CNT_W-1:0]        cornerCnt;
    modport master (
        output start, position, matMask, outReady,
        input  posReaden, outAddr, outIdx, outValid, busy, done, cornerCnt
    );
    modport slave (
        input  start, position, matMask, outReady,
        output posReaden, outAddr, outIdx, outValid, busy, done, cornerCnt
    );
endinterface

// File: rtl/pos_drain.sv
// pos_drain: snapshots the position register file and streams matched corner addresses, lowest index first.
module pos_drain #(
    parameter int ADDR_W = 15,
    parameter int N_POS  = 16,
    parameter int CNT_W  = 5
) (
    input logic          clk,
    input logic          rst,
    pos_drain_if.slave   bus
);
    localparam int IDX_W = $clog2(N_POS);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
    state_t            state, next;
    logic [ADDR_W-1:0] ent [N_POS];
    logic [N_POS-1:0]  rem, rem_next;
    logic [IDX_W-1:0]  sel;
    logic [CNT_W-1:0]  cnt;
    logic              pos_en, valid, fire;
    // Priority encoder: lowest remaining matched entry wins.
    always_comb begin
        sel = '0;
        for (int i = N_POS - 1; i >= 0; i--)
            if (rem[i]) sel = IDX_W'(i);
    end
    assign valid    = (state == DRAIN) && (|rem);
    assign fire     = valid & bus.outReady;
    assign rem_next = fire ? rem & ~(N_POS'(1) << sel) : rem;
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= next;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = bus.start ? REQ : IDLE;
            REQ:     next = DRAIN;
            DRAIN:   next = (|rem_next) ? DRAIN : DONE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_en <= 1'b0;
            rem    <= '0;
            cnt    <= '0;
            for (int i = 0; i < N_POS; i++) ent[i] <= '0;
        end else begin
            pos_en <= (next == REQ);
            if (state == REQ) begin
                rem <= bus.matMask;
                cnt <= '0;
                for (int i = 0; i < N_POS; i++)
                    ent[i] <= bus.position[N_POS*ADDR_W-1-ADDR_W*i -: ADDR_W];
            end else if (fire) begin
                rem <= rem_next;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
    assign bus.posReaden = pos_en;
    assign bus.outValid  = valid;
    assign bus.outIdx    = valid ? sel : '0;
    assign bus.outAddr   = valid ? ent[sel] : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.cornerCnt = cnt;
endmodule

// File: tb/tb_pos_drain.sv
// tb_pos_drain: randomized drains checked against a queue-of-expected-beats model of the corner stream.
module tb_pos_drain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    logic [14:0] ent [16];
    logic [15:0] mask;
    pos_drain_if bus ();
    pos_drain dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got %0h want %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Cycle 0 drives start; every later cycle is checked at the falling edge.
    task automatic run_drain(input logic [63:0] rdy, input bit meddle);
        int q[$];
        int cnt;
        int c;
        logic [239:0] pos;
        for (int i = 0; i < 16; i++) begin
            pos[239-15*i -: 15] = ent[i];
            if (mask[i]) q.push_back(i);
        end
        cnt = q.size();
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);
        bus.start = 1'b1; bus.position = pos; bus.matMask = mask; bus.outReady = rdy[0];
        @(negedge clk);
        bus.start = 1'b0; bus.outReady = rdy[1];
        check("req_posreaden", 32'(bus.posReaden), 1);
        check("req_busy", 32'(bus.busy), 1);
        check("req_valid", 32'(bus.outValid), 0);
        c = 2;
        while (q.size() > 0 && c < 64) begin
            @(negedge clk);
            bus.start = meddle && c == 4;
            if (meddle && c == 3) begin bus.position = '0; bus.matMask = '0; end
            check("beat_valid", 32'(bus.outValid), 1);
            check("beat_idx", 32'(bus.outIdx), 32'(q[0]));
            check("beat_addr", 32'(bus.outAddr), 32'(ent[q[0]]));
            check("beat_posreaden", 32'(bus.posReaden), 0);
            check("beat_done", 32'(bus.done), 0);
            bus.outReady = rdy[c];
            if (rdy[c]) void'(q.pop_front());
            c++;
        end
        if (q.size() > 0) check("drain_timeout", 32'(q.size()), 0);
        bus.start = 1'b0;
        if (cnt == 0) begin
            @(negedge clk);
            check("empty_valid", 32'(bus.outValid), 0);
            check("empty_done", 32'(bus.done), 0);
            check("empty_busy", 32'(bus.busy), 1);
        end
        @(negedge clk);
        bus.outReady = 1'b0;
        check("done_pulse", 32'(bus.done), 1);
        check("done_busy", 32'(bus.busy), 1);
        check("done_valid", 32'(bus.outValid), 0);
        check("done_cnt", 32'(bus.cornerCnt), 32'(cnt));
        @(negedge clk);
        check("after_done", 32'(bus.done), 0);
        check("after_busy", 32'(bus.busy), 0);
        check("after_cnt", 32'(bus.cornerCnt), 32'(cnt));
        check("after_posreaden", 32'(bus.posReaden), 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.position = '0; bus.matMask = '0; bus.outReady = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.outValid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_posreaden", 32'(bus.posReaden), 0);
        check("rst_cnt", 32'(bus.cornerCnt), 0);
        check("rst_addr", 32'(bus.outAddr), 0);
        check("rst_idx", 32'(bus.outIdx), 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ent[i] = 15'h100 + 15'(i);
        mask = 16'h0000;
        run_drain('1, 1'b0);
        mask = 16'hFFFF;
        run_drain('1, 1'b0);
        ent[0] = 15'h1234; ent[15] = 15'h7FFF; mask = 16'h8001;
        run_drain('1, 1'b0);
        mask = 16'h0006;
        run_drain(~64'h1C, 1'b0);
        for (int i = 0; i < 16; i++) ent[i] = 15'h100 + 15'(i);
        mask = 16'hFFFF;
        run_drain('1, 1'b1);
        // Abort a full drain in cycle 5 and confirm nothing leaks out.
        @(negedge clk);
        bus.start = 1'b1; bus.matMask = 16'hFFFF; bus.outReady = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 32'(bus.outValid), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_cnt", 32'(bus.cornerCnt), 0);
        check("abort_done", 32'(bus.done), 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 0);
        end
        run_drain('1, 1'b0);
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 16; i++) ent[i] = 15'($urandom);
            mask = 16'($urandom) & 16'($urandom | $urandom);
            run_drain({24'hFFFFFF, 8'($urandom), $urandom | $urandom}, 1'b0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
